uart_rx: RTL and testbench

Serial receive side of the UART link, paired with the transmitter and its baud-rate clock divider. Samples the asynchronous `rx` line with an oversampling tick derived from the native clock and recovers 8N1 frames: 1 start bit, `DATA_BITS` data bits LSB first, no parity, 1 stop bit. Each received byte is presented as a one-cycle `valid` pulse, and a bad stop bit is flagged separately.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_rx_baud_tick_gen.sv | 34 +++
 rtl/uart_rx.sv | 146 ++++++++++++++
 tb/tb_uart_rx.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the baud divisor helper
// used by both the RX tick generator and the TX clock divider.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_rx_state_t;

  // Native clock cycles per oversample tick (truncating).
  function automatic int baud_divisor(input int native, input int baud, input int oversample);
    return native / (baud * oversample);
  endfunction

endpackage

// File: rtl/uart_rx_baud_tick_gen.sv
// Oversample tick generator with phase restart, so the receiver can align its
// sampling grid to the falling edge of each start bit.
module baud_tick_gen #(
  parameter int DIVISOR = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int CW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

  generate
    if (DIVISOR < 1) begin : g_bad_divisor
      $error("baud_tick_gen: DIVISOR must be >= 1");
    end
  endgenerate

  logic [CW-1:0] cnt;

  // Tick on the last count, so the first tick after restart lands DIVISOR cycles later.
  assign tick = (cnt == CW'(DIVISOR - 1));

  always_ff @(posedge clk) begin
    if (reset || restart)
      cnt <= '0;
    else if (tick)
      cnt <= '0;
    else
      cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1-style UART receiver: oversampled start-bit detection, mid-bit data
// sampling, stop-bit check with frame-error and line-break handling.
module uart_rx
  import uart_pkg::*;
#(
  parameter int NATIVE_CLK_FREQUENCY = 50_000_000,
  parameter int BAUD_RATE            = 115_200,
  parameter int OVERSAMPLE           = 16,
  parameter int DATA_BITS            = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_error,
  output logic                 busy
);

  localparam int DIVISOR = baud_divisor(NATIVE_CLK_FREQUENCY, BAUD_RATE, OVERSAMPLE);
  localparam int SW      = $clog2(OVERSAMPLE);
  localparam int BW      = $clog2(DATA_BITS + 1);

  localparam logic [SW-1:0] S_MID = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_END = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_END = BW'(DATA_BITS - 1);

  generate
    if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
      $error("uart_rx: OVERSAMPLE must be even and >= 4");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
      $error("uart_rx: DATA_BITS must be 5..9");
    end
  endgenerate

  logic rx_meta, rx_s;
  logic tick, restart;

  uart_rx_state_t state, state_n;
  logic [SW-1:0]        scnt;
  logic [BW-1:0]        bcnt;
  logic [DATA_BITS-1:0] sh;

  logic scnt_clr, shift_en, load, valid_n, ferr_n;

  baud_tick_gen #(.DIVISOR(DIVISOR)) u_tick (
    .clk     (clk),
    .reset   (reset),
    .restart (restart),
    .tick    (tick)
  );

  assign busy = (state != IDLE);

  always_comb begin
    state_n  = state;
    restart  = 1'b0;
    scnt_clr = 1'b0;
    shift_en = 1'b0;
    load     = 1'b0;
    valid_n  = 1'b0;
    ferr_n   = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          restart  = 1'b1;
          scnt_clr = 1'b1;
          state_n  = START;
        end
      end
      START: begin
        // Re-check the line half a bit in; a high level means a glitch.
        if (tick && scnt == S_MID) begin
          if (rx_s) begin
            state_n = IDLE;
          end else begin
            scnt_clr = 1'b1;
            state_n  = DATA;
          end
        end
      end
      DATA: begin
        if (tick && scnt == S_END) begin
          shift_en = 1'b1;
          if (bcnt == B_END) state_n = STOP;
        end
      end
      STOP: begin
        if (tick && scnt == S_END) begin
          load = 1'b1;
          if (rx_s) begin
            valid_n = 1'b1;
            state_n = IDLE;
          end else begin
            ferr_n  = 1'b1;
            state_n = BREAK;
          end
        end
      end
      BREAK: begin
        // Hold here while the line stays low so a break never decodes as data.
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta     <= 1'b1;
      rx_s        <= 1'b1;
      state       <= IDLE;
      scnt        <= '0;
      bcnt        <= '0;
      sh          <= '0;
      data        <= '0;
      valid       <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      rx_meta     <= rx;
      rx_s        <= rx_meta;
      state       <= state_n;
      valid       <= valid_n;
      frame_error <= ferr_n;

      if (scnt_clr)
        scnt <= '0;
      else if (tick)
        scnt <= (scnt == S_END) ? '0 : scnt + SW'(1);

      if (state == IDLE)
        bcnt <= '0;
      else if (shift_en)
        bcnt <= bcnt + BW'(1);

      // Line order is LSB first, so shifting in at the top leaves bit 0 at the bottom.
      if (shift_en)
        sh <= {rx_s, sh[DATA_BITS-1:1]};

      if (load)
        data <= sh;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: random and directed frames are queued as
// expected words; a monitor pops and checks every valid/frame_error pulse.
module tb_uart_rx;

  localparam int TB      = 160;
  localparam int LAT     = 1520;   // 9.5 bit periods from start edge to stop sample
  localparam int LAT_TOL = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] data;
  logic       valid, frame_error, busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] d;
    bit         fe;
    int         t0;
  } exp_t;

  exp_t q[$];

  uart_rx #(
    .NATIVE_CLK_FREQUENCY (1_600_000),
    .BAUD_RATE            (10_000),
    .OVERSAMPLE           (16),
    .DATA_BITS            (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .data        (data),
    .valid       (valid),
    .frame_error (frame_error),
    .busy        (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  // Monitor: every output pulse must match the oldest outstanding frame.
  always @(negedge clk) begin
    if (valid && frame_error)
      check("valid_and_frame_error_exclusive", 1, 0);
    if (valid || frame_error) begin
      if (q.size() == 0) begin
        check("unexpected_pulse", 1, 0);
      end else begin
        exp_t e;
        int   lat;
        e   = q.pop_front();
        lat = cyc - e.t0;
        check("pulse_kind_frame_error", int'(frame_error), int'(e.fe));
        check("data", int'(data), int'(e.d));
        checks++;
        if (lat < LAT - LAT_TOL || lat > LAT + LAT_TOL) begin
          errors++;
          $display("FAIL latency: got %0d cycles expected %0d +-%0d", lat, LAT, LAT_TOL);
        end
      end
    end
  end

  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One frame at the given bit period; the expectation is queued at the start edge.
  task automatic send(input logic [7:0] b, input bit stop_ok, input int per);
    exp_t e;
    e.d  = b;
    e.fe = !stop_ok;
    e.t0 = cyc;
    q.push_back(e);
    hold(1'b0, per);
    for (int i = 0; i < 8; i++) hold(b[i], per);
    hold(stop_ok ? 1'b1 : 1'b0, per);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (q.size() != 0 && n < 4 * TB) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(name, q.size(), 0);
  endtask

  initial begin
    logic [7:0] b;
    int         n;

    repeat (5) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("reset_data", int'(data), 0);
    check("reset_valid", int'(valid), 0);
    check("reset_frame_error", int'(frame_error), 0);
    check("reset_busy", int'(busy), 0);
    @(posedge clk); #1;
    hold(1'b1, 20);

    // Single frame
    send(8'hA5, 1'b1, TB);
    hold(1'b1, 20);
    drain("single_frame_drain");

    // Back-to-back, no idle gap
    send(8'h00, 1'b1, TB);
    send(8'hFF, 1'b1, TB);
    hold(1'b1, 20);
    drain("back_to_back_drain");

    // Glitch: short low pulse must not produce any output
    hold(1'b0, 10);
    check("glitch_busy_rises", int'(busy), 1);
    hold(1'b0, 30);
    rx = 1'b1;
    n = 0;
    while (busy && n < TB / 2) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("glitch_busy_falls", int'(busy), 0);
    hold(1'b1, 40);
    send(8'h3C, 1'b1, TB);
    hold(1'b1, 20);
    drain("after_glitch_drain");

    // Bad stop bit followed by a held-low line
    send(8'h55, 1'b0, TB);
    hold(1'b0, 1000 - TB);
    check("break_busy_held", int'(busy), 1);
    drain("frame_error_drain");
    hold(1'b1, 40);
    check("break_release_idle", int'(busy), 0);
    send(8'h81, 1'b1, TB);
    hold(1'b1, 20);
    drain("after_break_drain");

    // Reset in the middle of bit 4 of 0xC3
    b = 8'hC3;
    hold(1'b0, TB);
    for (int i = 0; i < 4; i++) hold(b[i], TB);
    hold(b[4], TB / 2);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    rx = 1'b1;
    @(negedge clk);
    check("midreset_data", int'(data), 0);
    check("midreset_valid", int'(valid), 0);
    check("midreset_frame_error", int'(frame_error), 0);
    check("midreset_busy", int'(busy), 0);
    @(posedge clk); #1;
    hold(1'b1, 2 * TB);
    check("midreset_no_pulse", q.size(), 0);
    send(8'h7E, 1'b1, TB);
    hold(1'b1, 20);
    drain("after_reset_drain");

    // Baud skew +3% (shorter bits) and -3% (longer bits)
    send(8'h96, 1'b1, 155);
    send(8'h96, 1'b1, 165);
    hold(1'b1, 20);
    drain("skew_drain");

    // Random words, random skew within tolerance, random idle gaps
    for (int k = 0; k < 16; k++) begin
      b = 8'($urandom_range(0, 255));
      send(b, 1'b1, int'($urandom_range(155, 165)));
      hold(1'b1, int'($urandom_range(0, 40)));
    end
    hold(1'b1, 20);
    drain("random_drain");
    check("final_idle", int'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
